// File: rtl/usb_ls_tx_pkg.sv
// Shared types for the low-speed USB transmitter: line states, FSM states,
// the SYNC pattern and the NRZI step.
package usb_ls_tx_pkg;

   // {D+, D-} as driven to the PHY; low-speed J is D- high.
   typedef enum logic [1:0] {
      SE0 = 2'b00,
      J   = 2'b01,
      K   = 2'b10
   } d_port_t;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP_SE0,
      EOP_J
   } tx_state_t;

   // Sent LSB first: 0000_0001.
   localparam logic [7:0] SYNC_PATTERN = 8'h80;

   function automatic d_port_t nrzi_next(input d_port_t cur, input logic b);
      d_port_t nxt;
      if (b) nxt = cur;
      else   nxt = (cur == J) ? K : J;
      return nxt;
   endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-phase counter: counts 0..CLKS_PER_BIT-1 and strobes bit_end on the last
// clock of each bit time. Held at zero while clear is high.
module usb_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bit_end
);

   localparam int unsigned W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] phase_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= '0;
      end else if (clear || bit_end) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_q + 1'b1;
      end
   end

   assign bit_end = !clear && (phase_q == LAST);

endmodule

// File: rtl/usb_ls_tx.sv
// Low-speed USB transmitter: SYNC, NRZI-encoded LSB-first payload with bit
// stuffing, then EOP. Line state and output enable are registered.
module usb_ls_tx
   import usb_ls_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output d_port_t    d,
   output logic       oe,
   output logic       busy
);

   tx_state_t  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [2:0] ones_q, ones_d;
   logic       stuff_q, stuff_d;
   d_port_t    line_q, line_d;
   logic       oe_q, oe_d;

   logic       bit_end;
   logic [2:0] ones_inc;
   logic       need_stuff;

   usb_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q == IDLE),
      .bit_end(bit_end)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         ones_q    <= '0;
         stuff_q   <= 1'b0;
         line_q    <= J;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         ones_q    <= ones_d;
         stuff_q   <= stuff_d;
         line_q    <= line_d;
         oe_q      <= oe_d;
      end
   end

   // shift_q[0] is the payload bit of the current slot unless it is a stuff slot.
   assign ones_inc   = shift_q[0] ? ones_q + 3'd1 : 3'd0;
   assign need_stuff = !stuff_q && (ones_inc == 3'd6);

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      ones_d    = ones_q;
      stuff_d   = stuff_q;
      line_d    = line_q;
      oe_d      = oe_q;
      tx_ready  = 1'b0;

      unique case (state_q)
         IDLE: begin
            line_d = J;
            oe_d   = 1'b0;
            if (tx_valid) begin
               state_d   = SYNC;
               shift_d   = SYNC_PATTERN;
               bit_idx_d = '0;
               ones_d    = '0;
               stuff_d   = 1'b0;
               line_d    = nrzi_next(J, SYNC_PATTERN[0]);
               oe_d      = 1'b1;
            end
         end

         SYNC, DATA: begin
            if (bit_end) begin
               ones_d = stuff_q ? 3'd0 : ones_inc;
               if (need_stuff) begin
                  stuff_d = 1'b1;
                  line_d  = nrzi_next(line_q, 1'b0);
               end else begin
                  stuff_d = 1'b0;
                  if (bit_idx_q == 3'd7) begin
                     // Byte boundary, including any trailing stuff bit.
                     tx_ready  = 1'b1;
                     bit_idx_d = '0;
                     if (tx_valid) begin
                        state_d = DATA;
                        shift_d = tx_data;
                        line_d  = nrzi_next(line_q, tx_data[0]);
                     end else begin
                        state_d = EOP_SE0;
                        line_d  = SE0;
                     end
                  end else begin
                     shift_d   = {1'b0, shift_q[7:1]};
                     bit_idx_d = bit_idx_q + 3'd1;
                     line_d    = nrzi_next(line_q, shift_q[1]);
                  end
               end
            end
         end

         EOP_SE0: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd1) begin
                  state_d   = EOP_J;
                  bit_idx_d = '0;
                  line_d    = J;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end

         EOP_J: begin
            if (bit_end) begin
               state_d = IDLE;
               oe_d    = 1'b0;
               line_d  = J;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign d    = line_q;
   assign oe   = oe_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_usb_ls_tx.sv
// Scoreboard bench for usb_ls_tx: a bit-level model predicts line states and
// tx_ready cycles per packet; the monitor pops and compares them.
module tb_usb_ls_tx;
   import usb_ls_tx_pkg::*;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   d_port_t    d;
   logic       oe;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] pkt[$];
   int         exp_line[$];
   int         exp_rdy[$];
   int         n_slots;

   always #5 clk = ~clk;

   usb_ls_tx #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_ready(tx_ready),
      .d       (d),
      .oe      (oe),
      .busy    (busy)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected slots: SYNC + payload with stuffing, NRZI from J, then SE0 SE0 J.
   task automatic build_model();
      int         bits[$];
      int         ones;
      int         line;
      logic [7:0] b;
      ones = 0;
      exp_line.delete();
      exp_rdy.delete();
      for (int k = 0; k <= pkt.size(); k++) begin
         b = (k == 0) ? SYNC_PATTERN : pkt[k-1];
         for (int i = 0; i < 8; i++) begin
            bits.push_back(int'(b[i]));
            if (b[i]) ones++;
            else ones = 0;
            if (ones == 6) begin
               bits.push_back(0);
               ones = 0;
            end
         end
         exp_rdy.push_back(bits.size() * CPB - 1);
      end
      line = int'(J);
      foreach (bits[i]) begin
         if (bits[i] == 0) line = (line == int'(J)) ? int'(K) : int'(J);
         exp_line.push_back(line);
      end
      exp_line.push_back(int'(SE0));
      exp_line.push_back(int'(SE0));
      exp_line.push_back(int'(J));
      n_slots = exp_line.size();
   endtask

   // pulse=1: tx_valid high for one clock only; otherwise held, bytes fed on tx_ready.
   task automatic run_packet(input bit pulse);
      int idx;
      int cur;
      int waitc;
      bit rdy_prev;
      idx      = 0;
      cur      = 0;
      waitc    = 0;
      rdy_prev = 1'b0;
      build_model();
      @(posedge clk);
      #1;
      tx_valid = 1'b1;
      tx_data  = (pkt.size() > 0) ? pkt[0] : 8'h00;
      while (!oe && waitc < 4) begin
         @(posedge clk);
         #1;
         waitc++;
         if (pulse) tx_valid = 1'b0;
      end
      check_eq("start_latency", waitc, 1);
      if (!oe) begin
         tx_valid = 1'b0;
         return;
      end
      for (int c = 0; c < n_slots * CPB; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
            if (rdy_prev && !pulse) begin
               idx++;
               if (idx < pkt.size()) tx_data = pkt[idx];
               else tx_valid = 1'b0;
            end
         end
         if (c % CPB == 0) cur = exp_line.pop_front();
         check_eq("line", int'(d), cur);
         check_eq("oe", int'(oe), 1);
         check_eq("busy", int'(busy), 1);
         if (tx_ready) begin
            if (exp_rdy.size() == 0) check_eq("rdy_extra", c, -1);
            else check_eq("rdy_cycle", c, exp_rdy.pop_front());
         end
         rdy_prev = tx_ready;
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      check_eq("oe_end", int'(oe), 0);
      check_eq("busy_end", int'(busy), 0);
      check_eq("line_end", int'(d), int'(J));
      check_eq("rdy_missing", exp_rdy.size(), 0);
      repeat (4) @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_d", int'(d), int'(J));
      check_eq("rst_oe", int'(oe), 0);
      check_eq("rst_ready", int'(tx_ready), 0);
      check_eq("rst_busy", int'(busy), 0);
      reset = 1'b0;
      repeat (3) @(posedge clk);

      pkt = '{8'h00};
      run_packet(1'b0);
      pkt = '{8'hFF};
      run_packet(1'b0);
      pkt = '{8'h01, 8'h80};
      run_packet(1'b0);
      pkt.delete();
      run_packet(1'b1);
      pkt = '{8'h3F, 8'h00};
      run_packet(1'b0);
      pkt = '{8'hFC, 8'h7E, 8'h03};
      run_packet(1'b0);
      pkt.delete();
      for (int i = 0; i < 3; i++) pkt.push_back(8'($urandom_range(0, 255)));
      run_packet(1'b0);

      // Abort mid-byte with an asynchronous reset between clock edges.
      @(posedge clk);
      #1;
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      repeat (200) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_eq("abort_d", int'(d), int'(J));
      check_eq("abort_oe", int'(oe), 0);
      check_eq("abort_busy", int'(busy), 0);
      tx_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      pkt = '{8'hA5};
      run_packet(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
